// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC register and a byte-loadable, big-endian instruction memory
// filled by the debug loader. The optional sticky HALT detection (fetching
// 32'hFFFF_FFFF stops the PC) is compiled in when IF_STAGE_HALT_DETECT_EN
// is defined. Without it, o_halted is tied to 0.
//
// Loader strobe semantics: i_instruction_wr is a valid-only strobe with no
// ready. A byte is accepted on the rising edge when i_instruction_wr=1 and
// o_full_mem=0. Strobes while o_full_mem=1 are dropped silently.
module if_stage #(
   parameter int PC_SIZE           = 32,
   parameter int BUS_SIZE          = 32,
   parameter int MEM_SIZE_IN_WORDS = 64
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_halt,
   input  logic                i_not_load,
   input  logic                i_next_pc_src,
   input  logic [PC_SIZE-1:0]  i_next_not_seq_pc,
   input  logic                i_instruction_wr,
   input  logic [7:0]          i_instruction,
   output logic                o_full_mem,
   output logic                o_empty_mem,
   output logic                o_halted,
   output logic [PC_SIZE-1:0]  o_pc,
   output logic [PC_SIZE-1:0]  o_next_seq_pc,
   output logic [BUS_SIZE-1:0] o_instruction
);

   localparam int MEM_BYTES = 4 * MEM_SIZE_IN_WORDS;
   localparam int AW        = $clog2(MEM_BYTES);
   localparam int PW        = AW + 1;
   localparam logic [PW-1:0]        PTR_FULL   = PW'(MEM_BYTES);
   localparam logic [PC_SIZE-3:0]   WORD_LIMIT = (PC_SIZE-2)'(MEM_SIZE_IN_WORDS);
   localparam logic [PC_SIZE-1:0]   PC_STEP    = PC_SIZE'(4);

   logic [7:0]         mem [MEM_BYTES];
   logic [PW-1:0]      ptr;
   logic [PC_SIZE-1:0] pc;
   logic               halted;
   logic               halt_hit;
   logic               advance;
   logic [PC_SIZE-3:0] word_idx;
   logic               in_range;
   logic               load_ok;
   logic               unused_tgt_lsbs;

   // Redirect targets are word-aligned by dropping their two LSBs.
   assign unused_tgt_lsbs = ^i_next_not_seq_pc[1:0];

   assign o_pc          = pc;
   assign o_next_seq_pc = pc + PC_STEP;
   assign o_full_mem    = (ptr == PTR_FULL);
   assign o_empty_mem   = (ptr == '0);
   assign o_halted      = halted;
   assign load_ok       = i_instruction_wr & ~o_full_mem;
   assign advance       = i_enable & ~i_halt & ~i_not_load & ~halted;

   assign word_idx = pc[PC_SIZE-1:2];
   assign in_range = (word_idx < WORD_LIMIT);

   // Big-endian word read. An out-of-range index reads as NOP and does not wrap.
   always_comb begin
      o_instruction = '0;
      if (in_range) begin
         o_instruction = BUS_SIZE'({mem[{word_idx[AW-3:0], 2'b00}],
                                    mem[{word_idx[AW-3:0], 2'b01}],
                                    mem[{word_idx[AW-3:0], 2'b10}],
                                    mem[{word_idx[AW-3:0], 2'b11}]});
      end
   end

`ifdef IF_STAGE_HALT_DETECT_EN
   logic is_halt_word;
   assign is_halt_word = (o_instruction == '1);
   assign halt_hit     = advance & is_halt_word;

   // Sticky halted flag: it sets when a HALT word is fetched on an advancing cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset)       halted <= 1'b0;
      else if (halt_hit) halted <= 1'b1;
   end
`else
   assign halt_hit = 1'b0;
   assign halted   = 1'b0;
`endif

   // PC register. Redirect has priority over sequential. A HALT fetch freezes the PC.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc <= '0;
      end else if (advance && !halt_hit) begin
         if (i_next_pc_src) pc <= {i_next_not_seq_pc[PC_SIZE-1:2], 2'b00};
         else               pc <= pc + PC_STEP;
      end
   end

   // Loader write pointer. It saturates at the byte capacity.
   always_ff @(posedge i_clk) begin
      if (i_reset)      ptr <= '0;
      else if (load_ok) ptr <= ptr + PW'(1);
   end

   // Byte memory. It clears on reset and the loader writes one byte per strobe.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
      end else if (load_ok) begin
         mem[ptr[AW-1:0]] <= i_instruction;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized cycles,
// checked against a byte-array reference model of the fetch stage.
module tb_if_stage;

   localparam int NBYTES = 256;
`ifdef IF_STAGE_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, en, hlt, nl, src, wr;
   logic [31:0] tgt;
   logic [7:0]  wbyte;
   logic        full, empty, halted;
   logic [31:0] pc, seq_pc, instr;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [7:0]  mem_m [NBYTES];
   int          ptr_m;
   logic [31:0] pc_m;
   bit          halted_m;

   // clock / reset block
   always #5 clk = ~clk;

   if_stage dut (
      .i_clk(clk), .i_reset(rst), .i_enable(en), .i_halt(hlt), .i_not_load(nl),
      .i_next_pc_src(src), .i_next_not_seq_pc(tgt), .i_instruction_wr(wr),
      .i_instruction(wbyte), .o_full_mem(full), .o_empty_mem(empty),
      .o_halted(halted), .o_pc(pc), .o_next_seq_pc(seq_pc), .o_instruction(instr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_fetch(input logic [31:0] a);
      int w;
      w = int'(a / 4);
      if (a >= 32'(NBYTES)) return 32'h0;
      return (32'(mem_m[4*w]) << 24) + (32'(mem_m[4*w+1]) << 16) +
             (32'(mem_m[4*w+2]) << 8) + 32'(mem_m[4*w+3]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
      ptr_m = 0; pc_m = 32'h0; halted_m = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},    pc,     pc_m);
      chk({tag, ".seq"},   seq_pc, pc_m + 32'd4);
      chk({tag, ".instr"}, instr,  m_fetch(pc_m));
      chk({tag, ".full"},  {31'b0, full},   {31'b0, ptr_m == NBYTES});
      chk({tag, ".empty"}, {31'b0, empty},  {31'b0, ptr_m == 0});
      chk({tag, ".halt"},  {31'b0, halted}, {31'b0, halted_m});
   endtask

   // driver: one clock with the given inputs, model update, then check
   task automatic cycle(input string tag, input bit r, input bit e, input bit h,
                        input bit n, input bit s, input logic [31:0] t,
                        input bit w, input logic [7:0] b);
      logic [31:0] cur;
      bit adv;
      rst = r; en = e; hlt = h; nl = n; src = s; tgt = t; wr = w; wbyte = b;
      #1;
      cur = m_fetch(pc_m);
      if (!r) chk({tag, ".pre_instr"}, instr, cur);
      if (r) begin
         model_reset();
      end else begin
         adv = e && !h && !n && !halted_m;
         if (adv && HALT_EN && cur == 32'hFFFF_FFFF) halted_m = 1'b1;
         else if (adv) pc_m = s ? (t & ~32'd3) : pc_m + 32'd4;
         if (w && ptr_m < NBYTES) begin
            mem_m[ptr_m] = b;
            ptr_m++;
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      cycle("reset", 1, 0, 0, 0, 0, 32'h0, 0, 8'h0);
   endtask

   task automatic load(input string tag, input logic [7:0] b);
      cycle(tag, 0, 0, 0, 0, 0, 32'h0, 1, b);
   endtask

   task automatic step(input string tag);
      cycle(tag, 0, 1, 0, 0, 0, 32'h0, 0, 8'h0);
   endtask

   task automatic jump(input string tag, input logic [31:0] t);
      cycle(tag, 0, 1, 0, 0, 1, t, 0, 8'h0);
   endtask

   initial begin
      logic [7:0] t1 [8];
      logic [7:0] last;
      t1 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
      rst = 1; en = 0; hlt = 0; nl = 0; src = 0; tgt = 0; wr = 0; wbyte = 0;
      model_reset();
      @(negedge clk);

      // 1: reset values, small program, one enabled step
      do_reset();
      chk("t1.rst_seq", seq_pc, 32'h4);
      chk("t1.rst_empty", {31'b0, empty}, 32'h1);
      for (int i = 0; i < 8; i++) load("t1.load", t1[i]);
      chk("t1.instr0", instr, 32'h0000_0001);
      chk("t1.empty0", {31'b0, empty}, 32'h0);
      step("t1.step");
      chk("t1.pc4", pc, 32'h4);
      chk("t1.instr1", instr, 32'h0000_0002);

      // 2: fill memory, then one dropped extra write
      do_reset();
      last = 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
         last = 8'($urandom_range(0, 255));
         load("t2.fill", last);
      end
      chk("t2.full", {31'b0, full}, 32'h1);
      load("t2.extra", ~last);
      jump("t2.j252", 32'd252);
      chk("t2.mem255", {24'b0, instr[7:0]}, {24'b0, last});

      // 3: redirect alignment and hazard stall
      do_reset();
      step("t3.s1");
      step("t3.s2");
      chk("t3.pc8", pc, 32'h8);
      jump("t3.j23", 32'h23);
      chk("t3.pc20", pc, 32'h20);
      chk("t3.seq24", seq_pc, 32'h24);
      for (int i = 0; i < 3; i++) cycle("t3.stall", 0, 1, 0, 1, 0, 32'h0, 0, 8'h0);
      chk("t3.hold", pc, 32'h20);
      cycle("t3.halt_in", 0, 1, 1, 0, 1, 32'h40, 0, 8'h0);
      cycle("t3.disabled", 0, 0, 0, 0, 0, 32'h0, 0, 8'h0);

      // 4: out-of-range fetch and PC wrap
      jump("t4.j100", 32'h100);
      chk("t4.nop", instr, 32'h0);
      jump("t4.jfffc", 32'hFFFF_FFFC);
      chk("t4.seq_wrap", seq_pc, 32'h0);
      step("t4.wrap");
      chk("t4.pc0", pc, 32'h0);

      // 5: HALT word at word 2
      do_reset();
      for (int i = 0; i < 8; i++) load("t5.load", 8'h00);
      for (int i = 0; i < 4; i++) load("t5.halt", 8'hFF);
      for (int i = 0; i < 4; i++) step("t5.run");
      chk("t5.pc", pc, HALT_EN ? 32'h8 : 32'h10);
      chk("t5.halted", {31'b0, halted}, {31'b0, HALT_EN});
      cycle("t5.rst_busy", 1, 1, 0, 0, 0, 32'h0, 1, 8'h55);
      chk("t5.rst_pc", pc, 32'h0);
      chk("t5.rst_halted", {31'b0, halted}, 32'h0);

      // same-cycle write and fetch of the current word
      cycle("t6.rw", 0, 0, 0, 0, 0, 32'h0, 1, 8'hA5);
      chk("t6.after", instr, 32'hA500_0000);

      // randomized cycles
      for (int i = 0; i < 600; i++) begin
         bit r, s, w;
         logic [31:0] t;
         r = ($urandom_range(0, 149) == 0);
         s = ($urandom_range(0, 5) == 0);
         w = ($urandom_range(0, 2) != 0);
         t = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 300));
         cycle("rand", r, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 5) == 0, s, t, w,
               ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
